multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control unit for a classic multicycle MIPS-style datapath. It is a Moore
// FSM: every datapath strobe and select comes from the current state alone.
// There are two exceptions. In FETCH, irwrite and pcwrite follow mem_ready.
// In DECODE, the illegal pulse follows the opcode.
//
// Optional feature:
//   MC_ORI_EN  When defined, adds the ori path (ORIEX, ORIWB, opcode 001101).
//              When undefined, ori decodes as illegal. Codes 10-11 then
//              behave like the other unused codes.
//
// Memory handshake: mem_ready=1 in a memory state (FETCH, MEMRD, MEMWR)
// means the access completes at the next rising edge, and the FSM advances
// at that edge. While mem_ready=0 the FSM stays in the memory state. All
// outputs then hold their values. Other states ignore mem_ready.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   opcode[5:0]  in   instruction[31:26], sampled in DECODE
//   mem_ready    in   memory completes the current access this cycle
//   pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
//   regdest, regwrite, alusrca                          out  datapath strobes
//   alusrcb[1:0], aluop[1:0], pcsource[1:0]             out  datapath selects
//   state[3:0]   out  current state code (debug)
//   illegal      out  one-cycle pulse in DECODE on an unrecognised opcode
//   retired[15:0] out count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pcwrite,
  output logic        pcwritecond,
  output logic        iord,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        irwrite,
  output logic        regdest,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic [1:0]  pcsource,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
`ifdef MC_ORI_EN
    S_JUMP   = 4'd9,
    S_ORIEX  = 4'd10,
    S_ORIWB  = 4'd11
`else
    S_JUMP   = 4'd9
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ORI_EN
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  state_e      state_q, state_d;
  logic [15:0] retired_q, retired_d;
  // The opcode is only guaranteed in DECODE. Remember lw vs sw so that
  // MEMADR can pick its successor without looking at opcode again.
  logic        is_sw_q, is_sw_d;
  logic        retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= 16'd0;
      is_sw_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      is_sw_q   <= is_sw_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_sw_d     = is_sw_q;
    retire      = 1'b0;
    illegal     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    regdest     = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;

    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        // The IR and PC+4 are committed only when the fetch completes.
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_RTYPE: state_d = S_EXEC;
          OP_LW: begin
            state_d = S_MEMADR;
            is_sw_d = 1'b0;
          end
          OP_SW: begin
            state_d = S_MEMADR;
            is_sw_d = 1'b1;
          end
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
`ifdef MC_ORI_EN
          OP_ORI:   state_d = S_ORIEX;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdest  = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
`ifdef MC_ORI_EN
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
        state_d = S_ORIWB;
      end
      S_ORIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
`endif
      // Unused codes: all outputs stay 0 and the FSM recovers to FETCH.
      default: state_d = S_FETCH;
    endcase

    // The counter wraps naturally from 0xFFFF to 0x0000.
    retired_d = retire ? retired_q + 16'd1 : retired_q;
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control. Each instruction is expanded
// into the cycle-by-cycle list of results the specification predicts:
// state code, control vector, illegal and retired. That list is pushed onto
// exp_q as the opcode is applied. Entries are then popped one per clock and
// compared on the falling edge. mem_ready for each cycle travels inside the
// queue entry.
//
// With MC_ORI_EN defined, the ori path is expected. Without it, ori is
// expected to decode as illegal.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int W = 38;  // {mr[37], st[36:33], ctrl[32:17], ill[16], ret[15:0]}

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
  logic        irwrite, regdest, regwrite, alusrca;
  logic [1:0]  alusrcb, aluop, pcsource;
  logic [3:0]  state;
  logic        illegal;
  logic [15:0] retired;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .memtoreg    (memtoreg),
    .irwrite     (irwrite),
    .regdest     (regdest),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsource    (pcsource),
    .state       (state),
    .illegal     (illegal),
    .retired     (retired)
  );

  logic [15:0] ctrl_got;
  assign ctrl_got = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
                     irwrite, regdest, regwrite, alusrca, alusrcb, aluop, pcsource};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_ret;
  int           checks;
  int           failures;
  int           cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected control vector for a state, built from the per-state output
  // list. Ordering matches ctrl_got.
  function automatic logic [15:0] ctrl_exp(input logic [3:0] st, input logic mr);
    logic pw, pwc, io, mrd, mw, m2r, irw, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, io, mrd, mw, m2r, irw, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0: begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1: asb = 2'b11;
      4'd2: begin asa = 1'b1; asb = 2'b10; end
      4'd3: begin mrd = 1'b1; io = 1'b1; end
      4'd4: begin rw = 1'b1; m2r = 1'b1; end
      4'd5: begin mw = 1'b1; io = 1'b1; end
      4'd6: begin asa = 1'b1; aop = 2'b10; end
      4'd7: begin rw = 1'b1; rd = 1'b1; end
      4'd8: begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
      4'd9: begin pw = 1'b1; psrc = 2'b10; end
`ifdef MC_ORI_EN
      4'd10: begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
      4'd11: rw = 1'b1;
`endif
      default: ;
    endcase
    return {pw, pwc, io, mrd, mw, m2r, irw, rd, rw, asa, asb, aop, psrc};
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (op == OP_J);
`ifdef MC_ORI_EN
    ok = ok || (op == OP_ORI);
`endif
    return ok;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_cycle(input logic [3:0] st, input logic mr, input logic ill);
    exp_q.push_back({mr, st, ctrl_exp(st, mr), ill, exp_ret});
  endtask

  // Pops one entry per clock: drives mem_ready just after the rising edge
  // and compares on the falling edge.
  task automatic run_q();
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready = e[37];
      @(negedge clk);
      check_eq("state",   64'(state),    64'(e[36:33]));
      check_eq("ctrl",    64'(ctrl_got), 64'(e[32:17]));
      check_eq("illegal", 64'(illegal),  64'(e[16]));
      check_eq("retired", 64'(retired),  64'(e[15:0]));
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- driver ----------------
  // fs: FETCH stall cycles, ms: MEMRD/MEMWR stall cycles.
  task automatic do_instr(input logic [5:0] op, input int fs, input int ms);
    logic ret;
    ret = 1'b0;
    opcode = op;
    for (int i = 0; i < fs; i++) push_cycle(4'd0, 1'b0, 1'b0);
    push_cycle(4'd0, 1'b1, 1'b0);
    push_cycle(4'd1, rnd_bit(), !op_legal(op));
    if (op_legal(op)) begin
      ret = 1'b1;
      case (op)
        OP_LW: begin
          push_cycle(4'd2, rnd_bit(), 1'b0);
          for (int i = 0; i < ms; i++) push_cycle(4'd3, 1'b0, 1'b0);
          push_cycle(4'd3, 1'b1, 1'b0);
          push_cycle(4'd4, rnd_bit(), 1'b0);
        end
        OP_SW: begin
          push_cycle(4'd2, rnd_bit(), 1'b0);
          for (int i = 0; i < ms; i++) push_cycle(4'd5, 1'b0, 1'b0);
          push_cycle(4'd5, 1'b1, 1'b0);
        end
        OP_RTYPE: begin
          push_cycle(4'd6, rnd_bit(), 1'b0);
          push_cycle(4'd7, rnd_bit(), 1'b0);
        end
        OP_BEQ: push_cycle(4'd8, rnd_bit(), 1'b0);
        OP_J:   push_cycle(4'd9, rnd_bit(), 1'b0);
        default: begin
          push_cycle(4'd10, rnd_bit(), 1'b0);
          push_cycle(4'd11, rnd_bit(), 1'b0);
        end
      endcase
    end
    run_q();
    if (ret) exp_ret = exp_ret + 16'd1;
  endtask

  // ---------------- main sequence ----------------
  logic [5:0] ops [8];

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    exp_ret   = 16'd0;
    opcode    = OP_RTYPE;
    mem_ready = 1'b0;
    reset     = 1'b1;

    // While in reset: FETCH outputs, with irwrite/pcwrite following mem_ready.
    #2;
    check_eq("rst_state",   64'(state),    64'(4'd0));
    check_eq("rst_retired", 64'(retired),  64'(16'd0));
    check_eq("rst_illegal", 64'(illegal),  64'(1'b0));
    check_eq("rst_ctrl_mr0", 64'(ctrl_got), 64'(ctrl_exp(4'd0, 1'b0)));
    mem_ready = 1'b1;
    #1;
    check_eq("rst_ctrl_mr1", 64'(ctrl_got), 64'(ctrl_exp(4'd0, 1'b1)));
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_state", 64'(state), 64'(4'd0));
    reset = 1'b0;
    mem_ready = 1'b0;

    // Directed cases.
    do_instr(OP_LW,    0, 0);   // 0,1,2,3,4,0 and retired 0->1
    do_instr(OP_SW,    0, 3);   // memwrite held four cycles
    do_instr(OP_BEQ,   0, 0);
    do_instr(OP_J,     0, 0);
    do_instr(OP_BAD,   0, 0);   // illegal pulse, no retire
    do_instr(OP_ORI,   0, 0);
    do_instr(OP_RTYPE, 2, 0);
    do_instr(OP_LW,    1, 2);

    // Randomised mix with stalls.
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ORI, OP_BAD, 6'b000001};
    for (int n = 0; n < 40; n++)
      do_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3));

    // Reset asserted between edges while in EXEC.
    opcode = OP_RTYPE;
    push_cycle(4'd0, 1'b1, 1'b0);
    push_cycle(4'd1, 1'b0, 1'b0);
    run_q();
    check_eq("pre_rst_exec", 64'(state), 64'(4'd6));
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_state",   64'(state),   64'(4'd0));
    check_eq("async_rst_retired", 64'(retired), 64'(16'd0));
    check_eq("async_rst_ctrl",    64'(ctrl_got), 64'(ctrl_exp(4'd0, mem_ready)));
    @(posedge clk);
    #1;
    check_eq("no_rwb_state", 64'(state), 64'(4'd0));
    check_eq("no_rwb_retired", 64'(retired), 64'(16'd0));
    reset = 1'b0;
    exp_ret = 16'd0;

    do_instr(OP_J,  0, 0);
    do_instr(OP_SW, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
